// File: rtl/cg_timer_pkg.sv
// Shared types and defaults for the common-goods down-counting timer.
// Keeps the state encoding in one place so the timer and its users agree.
package cg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_e;

  localparam int DEFAULT_MISS_WIDTH = 8;

endpackage

// File: rtl/cg_prescaler.sv
// Cycle divider: while enabled, emits a one-cycle tick every i_setting+1 cycles.
// i_clear returns the divider to zero and overrides counting.
module cg_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_setting,
  input  logic             i_clear,
  output logic             o_tick
);

  logic [WIDTH-1:0] cnt_q;

  assign o_tick = i_enable && (cnt_q == i_setting);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_enable) begin
      cnt_q <= o_tick ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cg_down_timer.sv
// Programmable down-counting timer with reload, prescaler, one-shot/periodic
// modes and a valid/ready expiry event with a saturating missed-event counter.
module cg_down_timer
  import cg_timer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int MISS_WIDTH     = DEFAULT_MISS_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_load,
  input  logic [DATA_WIDTH-1:0]     i_load_value,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_periodic,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_clr_miss,
  output logic [DATA_WIDTH-1:0]     o_count,
  output logic                      o_running,
  output logic                      o_expire,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [MISS_WIDTH-1:0]     o_miss_count,
  output timer_state_e              o_dbg_state
);

  // Event handshake: an event is transferred on any cycle where
  // o_evt_valid && i_evt_ready; o_evt_valid stays high until then.

  timer_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0]   count_q, reload_q;
  logic [MISS_WIDTH-1:0]   miss_q;
  logic                    expire_q, evt_valid_q;
  logic                    tick, expiry;

  cg_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_enable  (state_q == RUN),
    .i_setting (i_prescale),
    .i_clear   (i_load || (state_q == IDLE)),
    .o_tick    (tick)
  );

  // A load wins over a same-cycle tick, so it also suppresses expiry.
  assign expiry = tick && (count_q == '0) && !i_load;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: if (i_start && !i_stop) state_d = RUN;
      RUN: begin
        if (expiry && !i_periodic) state_d = IDLE;
        else if (i_stop)           state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q  <= '0;
      reload_q <= '0;
    end else if (i_load) begin
      count_q  <= i_load_value;
      reload_q <= i_load_value;
    end else if (tick) begin
      if (count_q != '0) count_q <= count_q - DATA_WIDTH'(1);
      else if (i_periodic) count_q <= reload_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      expire_q    <= 1'b0;
      evt_valid_q <= 1'b0;
      miss_q      <= '0;
    end else begin
      expire_q <= expiry;
      if (expiry)                          evt_valid_q <= 1'b1;
      else if (evt_valid_q && i_evt_ready) evt_valid_q <= 1'b0;
      // An expiry is only lost when the previous event is still unaccepted.
      if (i_clr_miss)
        miss_q <= '0;
      else if (expiry && evt_valid_q && !i_evt_ready && (miss_q != '1))
        miss_q <= miss_q + MISS_WIDTH'(1);
    end
  end

  assign o_count      = count_q;
  assign o_running    = (state_q == RUN);
  assign o_expire     = expire_q;
  assign o_evt_valid  = evt_valid_q;
  assign o_miss_count = miss_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_cg_down_timer.sv
// Bench for cg_down_timer: directed scenarios with hand-derived expectations
// plus randomized traffic checked against a cycle-level reference model.
module tb_cg_down_timer;
  import cg_timer_pkg::*;

  localparam int DW = 32;
  localparam int PW = 8;
  localparam int MW = 2;
  localparam int MISS_MAX = (1 << MW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_load = 1'b0;
  logic [DW-1:0] i_load_value = '0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_periodic = 1'b0;
  logic [PW-1:0] i_prescale = '0;
  logic          i_clr_miss = 1'b0;
  logic          i_evt_ready = 1'b0;
  logic [DW-1:0] o_count;
  logic          o_running, o_expire, o_evt_valid;
  logic [MW-1:0] o_miss_count;
  timer_state_e  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  cg_down_timer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .MISS_WIDTH(MW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_load(i_load), .i_load_value(i_load_value),
    .i_start(i_start), .i_stop(i_stop), .i_periodic(i_periodic),
    .i_prescale(i_prescale), .i_clr_miss(i_clr_miss), .o_count(o_count),
    .o_running(o_running), .o_expire(o_expire), .o_evt_valid(o_evt_valid),
    .i_evt_ready(i_evt_ready), .o_miss_count(o_miss_count), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_load = 0; i_load_value = '0; i_start = 0; i_stop = 0; i_periodic = 0;
    i_prescale = '0; i_clr_miss = 0; i_evt_ready = 0;
  endtask

  task automatic do_reset();
    i_rstn = 0;
    clear_inputs();
    cyc(); cyc();
    i_rstn = 1;
  endtask

  task automatic test_reset();
    i_rstn = 0;
    clear_inputs();
    #2;
    n_tests++;
    if ({o_count, o_running, o_expire, o_evt_valid, o_miss_count} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: count=%0d run=%0b exp=%0b valid=%0b miss=%0d, expected all 0",
               o_count, o_running, o_expire, o_evt_valid, o_miss_count);
    end
    n_tests++;
    if (o_dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset state: got %0d expected %0d", o_dbg_state, IDLE);
    end
    cyc();
    i_rstn = 1;
  endtask

  task automatic test_oneshot();
    do_reset();
    i_load = 1; i_load_value = 3; i_start = 1;
    cyc();
    i_load = 0; i_start = 0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (o_count !== DW'(3 - k) || o_running !== 1'b1 || o_expire !== 1'b0) begin
        n_fail++;
        $display("FAIL oneshot count k=%0d: count=%0d run=%0b exp=%0b, expected count=%0d run=1 exp=0",
                 k, o_count, o_running, o_expire, 3 - k);
      end
      cyc();
    end
    n_tests++;
    if (o_expire !== 1'b1 || o_running !== 1'b0 || o_count !== '0 || o_evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot expiry: exp=%0b run=%0b count=%0d valid=%0b, expected 1 0 0 1",
               o_expire, o_running, o_count, o_evt_valid);
    end
    i_evt_ready = 1;
    cyc();
    n_tests++;
    if (o_expire !== 1'b0 || o_evt_valid !== 1'b0 || o_dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL oneshot after accept: exp=%0b valid=%0b state=%0d, expected 0 0 IDLE",
               o_expire, o_evt_valid, o_dbg_state);
    end
  endtask

  task automatic test_periodic();
    int exp_cnt;
    logic exp_e;
    do_reset();
    i_load = 1; i_load_value = 2; i_start = 1; i_prescale = 1; i_periodic = 1; i_evt_ready = 1;
    cyc();
    i_load = 0; i_start = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      exp_e = (k % 6 == 0);
      exp_cnt = 2 - (k % 6) / 2;
      n_tests++;
      if (o_count !== DW'(exp_cnt) || o_expire !== exp_e || o_evt_valid !== exp_e ||
          o_miss_count !== '0 || o_running !== 1'b1) begin
        n_fail++;
        $display("FAIL periodic k=%0d: count=%0d exp=%0b valid=%0b miss=%0d run=%0b, expected %0d %0b %0b 0 1",
                 k, o_count, o_expire, o_evt_valid, o_miss_count, o_running, exp_cnt, exp_e, exp_e);
      end
    end
  endtask

  task automatic test_miss();
    int exp_miss;
    do_reset();
    i_load = 1; i_load_value = 1; i_start = 1; i_periodic = 1;
    cyc();
    i_load = 0; i_start = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_miss = (k / 2) - 1;
      if (exp_miss < 0) exp_miss = 0;
      if (exp_miss > MISS_MAX) exp_miss = MISS_MAX;
      n_tests++;
      if (o_miss_count !== MW'(exp_miss) || o_evt_valid !== (k >= 2) ||
          o_expire !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL miss k=%0d: miss=%0d valid=%0b exp=%0b, expected %0d %0b %0b",
                 k, o_miss_count, o_evt_valid, o_expire, exp_miss, k >= 2, k % 2 == 0);
      end
    end
    cyc();
    i_clr_miss = 1;
    cyc();
    i_clr_miss = 0;
    n_tests++;
    if (o_miss_count !== '0 || o_expire !== 1'b1) begin
      n_fail++;
      $display("FAIL miss clear vs expiry: miss=%0d exp=%0b, expected 0 1", o_miss_count, o_expire);
    end
    cyc();
    i_evt_ready = 1;
    cyc();
    n_tests++;
    if (o_evt_valid !== 1'b1 || o_miss_count !== '0 || o_expire !== 1'b1) begin
      n_fail++;
      $display("FAIL accept with expiry: valid=%0b miss=%0d exp=%0b, expected 1 0 1",
               o_evt_valid, o_miss_count, o_expire);
    end
    cyc();
    n_tests++;
    if (o_evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept clears valid: valid=%0b expected 0", o_evt_valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    i_load = 1; i_load_value = 5; i_start = 1;
    cyc();
    i_load = 0; i_start = 0;
    cyc();
    i_stop = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_tests++;
      if (o_count !== DW'(3) || o_running !== 1'b0) begin
        n_fail++;
        $display("FAIL hold frozen k=%0d: count=%0d run=%0b, expected 3 0", k, o_count, o_running);
      end
    end
    i_start = 1;
    cyc();
    n_tests++;
    if (o_dbg_state !== HOLD || o_count !== DW'(3)) begin
      n_fail++;
      $display("FAIL hold start+stop: state=%0d count=%0d, expected HOLD 3", o_dbg_state, o_count);
    end
    i_stop = 0;
    cyc();
    i_start = 0;
    for (int k = 3; k >= 0; k--) begin
      n_tests++;
      if (o_count !== DW'(k) || o_running !== 1'b1) begin
        n_fail++;
        $display("FAIL hold resume: count=%0d run=%0b, expected %0d 1", o_count, o_running, k);
      end
      cyc();
    end
    n_tests++;
    if (o_expire !== 1'b1 || o_running !== 1'b0) begin
      n_fail++;
      $display("FAIL hold final expiry: exp=%0b run=%0b, expected 1 0", o_expire, o_running);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    i_load = 1; i_load_value = 4; i_start = 1;
    cyc();
    i_start = 0; i_load = 0;
    cyc();
    i_load = 1; i_load_value = 9;
    cyc();
    n_tests++;
    if (o_count !== DW'(9) || o_expire !== 1'b0 || o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL load over tick: count=%0d exp=%0b run=%0b, expected 9 0 1", o_count, o_expire, o_running);
    end
    i_load = 0;
    cyc();
    n_tests++;
    if (o_count !== DW'(8)) begin
      n_fail++;
      $display("FAIL count after reload: count=%0d expected 8", o_count);
    end
    i_load = 1; i_load_value = 0;
    cyc();
    cyc();
    n_tests++;
    if (o_count !== '0 || o_expire !== 1'b0 || o_evt_valid !== 1'b0 || o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL load over expiry: count=%0d exp=%0b valid=%0b run=%0b, expected 0 0 0 1",
               o_count, o_expire, o_evt_valid, o_running);
    end
    i_load = 0;
    cyc();
    n_tests++;
    if (o_expire !== 1'b1 || o_running !== 1'b0) begin
      n_fail++;
      $display("FAIL expiry after load 0: exp=%0b run=%0b, expected 1 0", o_expire, o_running);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_load = 1; i_load_value = 0; i_start = 1; i_periodic = 1;
    cyc();
    i_load = 0; i_start = 0;
    cyc(); cyc();
    #3;
    i_rstn = 0;
    #1;
    n_tests++;
    if ({o_count, o_running, o_expire, o_evt_valid, o_miss_count} !== '0) begin
      n_fail++;
      $display("FAIL async reset: count=%0d run=%0b exp=%0b valid=%0b miss=%0d, expected all 0",
               o_count, o_running, o_expire, o_evt_valid, o_miss_count);
    end
    cyc();
    i_rstn = 1;
    cyc(); cyc();
    n_tests++;
    if (o_dbg_state !== IDLE || o_count !== '0 || o_evt_valid !== 1'b0 || o_expire !== 1'b0) begin
      n_fail++;
      $display("FAIL after reset release: state=%0d count=%0d valid=%0b exp=%0b, expected IDLE 0 0 0",
               o_dbg_state, o_count, o_evt_valid, o_expire);
    end
  endtask

  // Reference model: modes 0 idle, 1 run, 2 hold; plain integer arithmetic.
  task automatic test_random();
    int unsigned m_cnt, m_rel, m_pc, m_miss, pre;
    int m_mode;
    bit m_valid, m_exp, tick, fire;
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      pre = $urandom_range(0, 2);
      i_prescale = PW'(pre);
      m_cnt = 0; m_rel = 0; m_pc = 0; m_miss = 0; m_mode = 0; m_valid = 0; m_exp = 0;
      for (int c = 0; c < 300; c++) begin
        i_load       = ($urandom_range(0, 7) == 0);
        i_load_value = DW'($urandom_range(0, 6));
        i_start      = ($urandom_range(0, 3) == 0);
        i_stop       = ($urandom_range(0, 9) == 0);
        i_periodic   = $urandom_range(0, 1);
        i_evt_ready  = ($urandom_range(0, 2) == 0);
        i_clr_miss   = ($urandom_range(0, 15) == 0);
        tick = (m_mode == 1) && (m_pc == pre);
        fire = tick && (m_cnt == 0) && !i_load;
        if (i_clr_miss) m_miss = 0;
        else if (fire && m_valid && !i_evt_ready && m_miss < MISS_MAX) m_miss++;
        if (fire) m_valid = 1;
        else if (m_valid && i_evt_ready) m_valid = 0;
        m_exp = fire;
        if (i_load) begin
          m_cnt = i_load_value; m_rel = i_load_value;
        end else if (tick) begin
          m_cnt = (m_cnt != 0) ? m_cnt - 1 : (i_periodic ? m_rel : 0);
        end
        if (i_load || m_mode == 0) m_pc = 0;
        else if (m_mode == 1) m_pc = tick ? 0 : m_pc + 1;
        if (m_mode == 1) begin
          if (fire && !i_periodic) m_mode = 0;
          else if (i_stop) m_mode = 2;
        end else if (i_start && !i_stop) m_mode = 1;
        cyc();
        n_tests++;
        if (o_count !== DW'(m_cnt) || o_running !== (m_mode == 1) || o_expire !== m_exp ||
            o_evt_valid !== m_valid || o_miss_count !== MW'(m_miss)) begin
          n_fail++;
          $display("FAIL random seg=%0d c=%0d: count=%0d run=%0b exp=%0b valid=%0b miss=%0d, expected %0d %0b %0b %0b %0d",
                   seg, c, o_count, o_running, o_expire, o_evt_valid, o_miss_count,
                   m_cnt, m_mode == 1, m_exp, m_valid, m_miss);
        end
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_miss();
    test_hold();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
